// File: rtl/pdm_capture_pkg.sv
// pdm_capture_pkg -- shared definitions for the PDM capture/dump controller.
//   DEF_DEPTH / DEF_CLK_DIV : default burst length and pdm_clk divider
//   ASCII_*                 : bytes emitted on the UART side
//   state_e                 : controller FSM states (ST_EOL only when
//                             PDM_CAPTURE_EOL_EN is defined)
//   bit_to_ascii()          : maps a captured PDM bit to '0' / '1'
package pdm_capture_pkg;

  localparam int DEF_DEPTH   = 128;
  localparam int DEF_CLK_DIV = 12;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_ONE  = 8'h31;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_OFFER   = 3'd2,
    ST_HOLD    = 3'd3
`ifdef PDM_CAPTURE_EOL_EN
    ,
    ST_EOL     = 3'd4
`endif
  } state_e;

  function automatic logic [7:0] bit_to_ascii(input logic b);
    return b ? ASCII_ONE : ASCII_ZERO;
  endfunction

endpackage

// File: rtl/pdm_capture_ctrl_clk_gen.sv
// pdm_clk_gen -- free-running divider producing the microphone clock.
//   clk, rst_n : system clock, async active-low reset
//   pdm_clk    : registered, high while the divider count is in its lower half
//   tick       : one-cycle strobe in the last cycle of each pdm_clk period
module pdm_clk_gen
  import pdm_capture_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic pdm_clk,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  assign tick    = (cnt == LAST);
  assign cnt_nxt = tick ? '0 : cnt + 1'b1;

  // pdm_clk is registered from the next count so it lines up with cnt
  // without a combinational path to the pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      pdm_clk <= 1'b1;
    end else begin
      cnt     <= cnt_nxt;
      pdm_clk <= (cnt_nxt < HALF);
    end
  end

endmodule

// File: rtl/pdm_capture_ctrl.sv
// pdm_capture_ctrl -- captures DEPTH PDM bits, then dumps them as ASCII
// '0'/'1' bytes to a UART transmitter.
//   clk, rst_n          : system clock, async active-low reset
//   start               : level request; sampled on a divider tick while idle
//   pdm_clk / pdm_dat   : microphone clock out / data in
//   uart_char / uart_go : byte and request towards the UART transmitter
//   uart_ready          : transmitter idle flag
//   busy / done         : not idle / one-cycle pulse at end of burst
//   dbg_state           : current FSM state
// Handshake: a byte is offered only when uart_ready=1 and uart_go=0;
// uart_go and uart_char then hold until uart_ready=0 is sampled, which
// counts as acceptance and drops uart_go.
// Optional macro PDM_CAPTURE_EOL_EN appends CR LF after each burst.
module pdm_capture_ctrl
  import pdm_capture_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       pdm_clk,
  input  logic       pdm_dat,
  output logic [7:0] uart_char,
  output logic       uart_go,
  input  logic       uart_ready,
  output logic       busy,
  output logic       done,
  output logic [2:0] dbg_state
);

  localparam int AW = $clog2(DEPTH);
  // Indices carry one extra bit so they can reach DEPTH without wrapping.
  localparam logic [AW:0] LAST_IDX = (AW + 1)'(DEPTH - 1);

  state_e      state;
  logic [AW:0] widx;
  logic [AW:0] ridx;
  logic        tick;
  logic        sample_buf [DEPTH];
`ifdef PDM_CAPTURE_EOL_EN
  logic        in_eol;
  logic        eol_lf;
`endif

  pdm_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .pdm_clk (pdm_clk),
    .tick    (tick)
  );

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  // Sample storage is not reset; an aborted burst leaves stale data.
  always_ff @(posedge clk) begin
    if (state == ST_CAPTURE && tick) begin
      sample_buf[widx[AW-1:0]] <= pdm_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      widx      <= '0;
      ridx      <= '0;
      uart_go   <= 1'b0;
      uart_char <= ASCII_ZERO;
      done      <= 1'b0;
`ifdef PDM_CAPTURE_EOL_EN
      in_eol    <= 1'b0;
      eol_lf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tick && start) begin
            widx  <= '0;
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (tick) begin
            widx <= widx + 1'b1;
            if (widx == LAST_IDX) begin
              ridx  <= '0;
              state <= ST_OFFER;
            end
          end
        end
        ST_OFFER: begin
          if (uart_ready && !uart_go) begin
            uart_char <= bit_to_ascii(sample_buf[ridx[AW-1:0]]);
            uart_go   <= 1'b1;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!uart_ready) begin
            uart_go <= 1'b0;
`ifdef PDM_CAPTURE_EOL_EN
            if (in_eol) begin
              if (eol_lf) begin
                done   <= 1'b1;
                in_eol <= 1'b0;
                eol_lf <= 1'b0;
                state  <= ST_IDLE;
              end else begin
                eol_lf <= 1'b1;
                state  <= ST_EOL;
              end
            end else begin
              ridx <= ridx + 1'b1;
              if (ridx == LAST_IDX) begin
                in_eol <= 1'b1;
                state  <= ST_EOL;
              end else begin
                state <= ST_OFFER;
              end
            end
`else
            ridx <= ridx + 1'b1;
            if (ridx == LAST_IDX) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              state <= ST_OFFER;
            end
`endif
          end
        end
`ifdef PDM_CAPTURE_EOL_EN
        ST_EOL: begin
          if (uart_ready && !uart_go) begin
            uart_char <= eol_lf ? ASCII_LF : ASCII_CR;
            uart_go   <= 1'b1;
            state     <= ST_HOLD;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
`timescale 1ns/1ps
module tb_pdm_capture_ctrl;

  localparam int DEPTH   = 128;
  localparam int CLK_DIV = 12;
`ifdef PDM_CAPTURE_EOL_EN
  localparam int N_BYTES = DEPTH + 2;
`else
  localparam int N_BYTES = DEPTH;
`endif
  localparam int WAIT_MAX = 4000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic       pdm_dat = 1'b0;
  logic       uart_ready = 1'b1;
  logic       pdm_clk;
  logic [7:0] uart_char;
  logic       uart_go;
  logic       busy;
  logic       done;
  logic [2:0] dbg_state;

  pdm_capture_ctrl #(.DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pdm_clk    (pdm_clk),
    .pdm_dat    (pdm_dat),
    .uart_char  (uart_char),
    .uart_go    (uart_go),
    .uart_ready (uart_ready),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Bench time base: rising edges since reset release. The divider is
  // free-running from reset, so its phase is cyc % CLK_DIV.
  int unsigned cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int done_cnt = 0;
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       bits_a [DEPTH];
  int unsigned t_start;
  int unsigned t_first;
  int          done_base;
  bit          aborted;

  // Reference: one ASCII digit per captured bit, optional CR LF trailer.
  task automatic build_expected(input int pattern);
    exp_q.delete();
    got_q.delete();
    for (int j = 0; j < DEPTH; j++) begin
      bits_a[j] = (pattern == 0) ? ((j % 2) == 0) : 1'($urandom_range(0, 1));
      exp_q.push_back(bits_a[j] ? 8'h31 : 8'h30);
    end
`ifdef PDM_CAPTURE_EOL_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  // Drives one burst: start on a tick, the bit for capture j held across
  // capture tick j, noise everywhere else; a UART model answers bytes.
  task automatic run_burst(input int pattern, input int smin, input int smax,
                           input bit toggle, input int abort_at);
    build_expected(pattern);
    done_base = done_cnt;
    aborted   = 1'b0;
    t_first   = 0;
    fork
      begin
        do @(negedge clk); while ((cyc % CLK_DIV) != CLK_DIV - 1);
        start   = 1'b1;
        t_start = cyc;
        pdm_dat = 1'($urandom_range(0, 1));
        for (int j = 0; j < DEPTH; j++) begin
          do begin
            @(negedge clk);
            pdm_dat = 1'($urandom_range(0, 1));
            start   = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
          end while ((cyc % CLK_DIV) != CLK_DIV - 1);
          pdm_dat = bits_a[j];
        end
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          pdm_dat = 1'($urandom_range(0, 1));
          start   = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        start = 1'b0;
      end
      begin
        int idx = 0;
        while (idx < N_BYTES) begin
          int w = 0;
          logic [7:0] ch;
          int stall;
          while (uart_go !== 1'b1 && w < WAIT_MAX) begin
            @(negedge clk);
            w++;
          end
          if (uart_go !== 1'b1) begin
            n_checks++;
            $display("FAIL byte_timeout idx=%0d uart_go=%b required 1 within %0d cycles",
                     idx, uart_go, WAIT_MAX);
            break;
          end
          if (idx == 0) t_first = cyc;
          ch = uart_char;
          got_q.push_back(ch);
          if (idx == abort_at) begin
            rst_n = 1'b0;
            #1;
            n_checks++;
            if (uart_go !== 1'b0 || busy !== 1'b0)
              $display("FAIL abort_async uart_go=%b busy=%b required 0/0", uart_go, busy);
            else n_pass++;
            repeat (4) @(negedge clk);
            n_checks++;
            if (done_cnt != done_base || busy !== 1'b0)
              $display("FAIL abort_no_done done_pulses=%0d busy=%b required 0/0",
                       done_cnt - done_base, busy);
            else n_pass++;
            rst_n   = 1'b1;
            aborted = 1'b1;
            break;
          end
          stall = $urandom_range(smin, smax);
          for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            n_checks++;
            if (uart_go !== 1'b1 || uart_char !== ch)
              $display("FAIL hold_stable idx=%0d go=%b char=%h required 1/%h",
                       idx, uart_go, uart_char, ch);
            else n_pass++;
          end
          uart_ready = 1'b0;
          @(negedge clk);
          n_checks++;
          if (uart_go !== 1'b0 || done !== (idx == N_BYTES - 1))
            $display("FAIL accept idx=%0d go=%b done=%b required 0/%b",
                     idx, uart_go, done, (idx == N_BYTES - 1));
          else n_pass++;
          uart_ready = 1'b1;
          idx++;
        end
      end
    join
  endtask

  // Compares received bytes with the reference, then checks for one done
  // pulse and a quiet idle period afterwards.
  task automatic check_burst(input string name);
    bit quiet = 1'b1;
    n_checks++;
    if (got_q.size() != N_BYTES)
      $display("FAIL %s_count got %0d required %0d", name, got_q.size(), N_BYTES);
    else n_pass++;
    for (int i = 0; i < got_q.size() && i < N_BYTES; i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL %s_byte[%0d] got %h required %h", name, i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    repeat (3 * CLK_DIV) begin
      @(negedge clk);
      if (uart_go !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (done_cnt - done_base != 1)
      $display("FAIL %s_done_pulses got %0d required 1", name, done_cnt - done_base);
    else n_pass++;
    n_checks++;
    if (!quiet) $display("FAIL %s_idle_after got activity required none", name);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (pdm_clk !== 1'b1 || uart_go !== 1'b0 || uart_char !== 8'h30 ||
        busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_values pdm_clk=%b go=%b char=%h busy=%b done=%b required 1/0/30/0/0",
               pdm_clk, uart_go, uart_char, busy, done);
    else n_pass++;
  endtask

  // Released at a falling edge; pdm_clk must follow 6 high / 6 low from
  // the very first rising edge.
  task automatic test_divider();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3 * CLK_DIV; k++) begin
      logic want = ((k % CLK_DIV) < CLK_DIV / 2);
      n_checks++;
      if (pdm_clk !== want)
        $display("FAIL pdm_clk_phase k=%0d got %b required %b", k, pdm_clk, want);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_basic_burst();
    int unsigned span;
    run_burst(0, 0, 2, 1'b0, -1);
    span = t_first - t_start;
    n_checks++;
    if (span < DEPTH * CLK_DIV - CLK_DIV || span > DEPTH * CLK_DIV + CLK_DIV)
      $display("FAIL capture_span got %0d cycles required %0d +/- %0d",
               span, DEPTH * CLK_DIV, CLK_DIV);
    else n_pass++;
    check_burst("basic");
  endtask

  task automatic test_uart_stall();
    run_burst(1, 50, 50, 1'b0, -1);
    check_burst("stall");
  endtask

  task automatic test_start_ignored();
    run_burst(1, 0, 3, 1'b1, -1);
    check_burst("start_busy");
  endtask

  task automatic test_reset_mid();
    run_burst(1, 0, 2, 1'b0, 40);
    n_checks++;
    if (!aborted || got_q.size() != 41)
      $display("FAIL abort_reached got %0d bytes required 41", got_q.size());
    else n_pass++;
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL abort_byte[%0d] got %h required %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    run_burst(1, 0, 2, 1'b0, -1);
    check_burst("after_abort");
  endtask

  initial begin
    test_reset();
    test_divider();
    test_basic_burst();
    test_uart_stall();
    test_start_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog simulation did not complete, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
